ov5640_reg_init_sequencer: RTL and testbench

OV5640_REG_INIT_SEQUENCER -- requirements
Module: ov5640_reg_init_sequencer

---
 rtl/ov5640_reg_init_sequencer.sv | 103 ++++++++++
 tb/tb_ov5640_reg_init_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_reg_init_sequencer.sv
// ov5640_reg_init_sequencer: walks a register table in ROM and issues SCCB writes,
// with a one-time power-up wait, inline delay entries and a per-write timeout.
module ov5640_reg_init_sequencer #(
    parameter int unsigned POWER_UP_CYCLES = 5000000,
    parameter int unsigned DELAY_UNIT      = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter int unsigned TABLE_DEPTH     = 256,
    parameter logic [7:0]  DEVICE_ADDR     = 8'h78,
    localparam int         AW              = $clog2(TABLE_DEPTH)
) (
    input  logic          clk,
    input  logic          rest_n,
    input  logic          start,
    output logic [AW-1:0] table_addr,
    input  logic [23:0]   table_data,
    output logic [7:0]    device_addr,
    output logic [15:0]   sub_addr,
    output logic          write,
    output logic [7:0]    write_data,
    output logic          read,
    output logic          resp_ready,
    input  logic          request_done,
    output logic          busy,
    output logic          init_done,
    output logic          init_error,
    output logic [AW:0]   entry_count
);
    typedef enum logic [3:0] {IDLE, POWER_UP, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, DONE, ERROR} state_t;
    state_t state, state_n, adv;
    logic [31:0] cnt;
    logic [23:0] ent;
    logic powered, last, go, pu_end, dly_end, to_end, is_end, is_dly, dly_zero, adv_idx;

    assign device_addr = DEVICE_ADDR;
    assign read        = 1'b0;
    assign resp_ready  = 1'b1;
    assign busy        = !(state inside {IDLE, DONE, ERROR});
    assign init_done   = state == DONE;
    assign init_error  = state == ERROR;
    assign go          = start && !busy;
    assign last        = table_addr == AW'(TABLE_DEPTH - 1);
    assign pu_end      = cnt == POWER_UP_CYCLES - 1;
    assign dly_end     = cnt == 32'(ent[7:0]) * DELAY_UNIT - 1;
    assign to_end      = cnt == TIMEOUT_CYCLES - 1;
    assign is_end      = table_data[23:8] == 16'hFFFF;
    assign is_dly      = table_data[23:8] == 16'hFFFE;
    assign dly_zero    = table_data[7:0] == 8'd0;
    // The last addressable entry finishes the run instead of wrapping the index.
    assign adv         = last ? DONE : FETCH;
    assign adv_idx     = !last && ((state == DECODE && is_dly && dly_zero) ||
                                   (state == WAIT_DONE && request_done) ||
                                   (state == DELAY && dly_end));

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:        state_n = start ? (powered ? FETCH : POWER_UP) : IDLE;
            POWER_UP:    state_n = pu_end ? FETCH : POWER_UP;
            FETCH:       state_n = DECODE;
            DECODE:      state_n = is_end ? DONE : !is_dly ? ISSUE : dly_zero ? adv : DELAY;
            ISSUE:       state_n = WAIT_DONE;
            WAIT_DONE:   state_n = request_done ? adv : to_end ? ERROR : WAIT_DONE;
            DELAY:       state_n = dly_end ? adv : DELAY;
            DONE, ERROR: state_n = start ? FETCH : state;
            default:     state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            table_addr  <= '0;
            entry_count <= '0;
            cnt         <= '0;
            ent         <= '0;
            sub_addr    <= '0;
            write_data  <= '0;
            write       <= 1'b0;
            powered     <= 1'b0;
        end else begin
            // One shared counter: it only runs in the three waiting states.
            cnt <= (state inside {POWER_UP, WAIT_DONE, DELAY}) ? cnt + 1 : '0;
            if (go) begin
                table_addr  <= '0;
                entry_count <= '0;
                powered     <= 1'b1;
            end
            if (adv_idx) table_addr <= table_addr + 1'b1;
            if (state == DECODE) ent <= table_data;
            if (state == ISSUE) begin
                sub_addr   <= ent[23:8];
                write_data <= ent[7:0];
                write      <= 1'b1;
            end
            if (state == WAIT_DONE && (request_done || to_end)) write <= 1'b0;
            if (state == WAIT_DONE && request_done) entry_count <= entry_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_ov5640_reg_init_sequencer.sv
// tb_ov5640_reg_init_sequencer: randomized tables checked against a cycle-cost model
// of the sequencer, plus directed power-up, delay, timeout, reset and depth-limit runs.
module tb_ov5640_reg_init_sequencer;
    localparam int PU = 10, DU = 4, TO = 20;

    logic clk, rest_n, start, request_done, start4, rd4;
    logic [3:0] table_addr;
    logic [1:0] table_addr4;
    logic [23:0] table_data, table_data4;
    logic [7:0] device_addr, write_data, device_addr4, write_data4;
    logic [15:0] sub_addr, sub_addr4;
    logic write, read, resp_ready, busy, init_done, init_error;
    logic write4, read4, resp_ready4, busy4, init_done4, init_error4;
    logic [4:0] entry_count;
    logic [2:0] entry_count4;
    logic [23:0] rom [16];
    logic [23:0] rom4 [4];
    int cyc = 0;
    int n_pass = 0, n_chk = 0;

    ov5640_reg_init_sequencer #(.POWER_UP_CYCLES(PU), .DELAY_UNIT(DU), .TIMEOUT_CYCLES(TO),
        .TABLE_DEPTH(16), .DEVICE_ADDR(8'h78)) dut (
        .clk(clk), .rest_n(rest_n), .start(start), .table_addr(table_addr), .table_data(table_data),
        .device_addr(device_addr), .sub_addr(sub_addr), .write(write), .write_data(write_data),
        .read(read), .resp_ready(resp_ready), .request_done(request_done), .busy(busy),
        .init_done(init_done), .init_error(init_error), .entry_count(entry_count));

    ov5640_reg_init_sequencer #(.POWER_UP_CYCLES(PU), .DELAY_UNIT(DU), .TIMEOUT_CYCLES(TO),
        .TABLE_DEPTH(4), .DEVICE_ADDR(8'h78)) dut4 (
        .clk(clk), .rest_n(rest_n), .start(start4), .table_addr(table_addr4), .table_data(table_data4),
        .device_addr(device_addr4), .sub_addr(sub_addr4), .write(write4), .write_data(write_data4),
        .read(read4), .resp_ready(resp_ready4), .request_done(rd4), .busy(busy4),
        .init_done(init_done4), .init_error(init_error4), .entry_count(entry_count4));

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        table_data  <= rom[table_addr];
        table_data4 <= rom4[table_addr4];
    end

    // SCCB responder and write monitor for the main instance
    int lat = 5, resp_left = 1000, k = 0, stab_err = 0, done_t = -1;
    bit wprev = 0, dprev = 0;
    int cap_t[$];
    logic [15:0] cap_sa[$];
    logic [7:0] cap_d[$];
    logic [15:0] hold_sa;
    logic [7:0] hold_d;
    always @(negedge clk) begin
        request_done = 0;
        if (write && !wprev) begin
            k = 0;
            cap_t.push_back(cyc);
            cap_sa.push_back(sub_addr);
            cap_d.push_back(write_data);
            hold_sa = sub_addr;
            hold_d = write_data;
        end else if (write) begin
            k++;
            if (sub_addr !== hold_sa || write_data !== hold_d) stab_err++;
        end
        if (write && k == lat - 1 && resp_left > 0) begin
            request_done = 1;
            resp_left--;
        end
        if (init_done && !dprev) done_t = cyc;
        wprev = write;
        dprev = init_done;
    end

    // Fixed-latency responder and address watcher for the depth-4 instance
    int n4 = 0, k4 = 0;
    bit w4p = 0, left0 = 0, wrap4 = 0;
    always @(negedge clk) begin
        rd4 = 0;
        if (write4 && !w4p) begin
            k4 = 0;
            n4++;
        end else if (write4) k4++;
        if (write4 && k4 == 2) rd4 = 1;
        if (table_addr4 != 2'd0) left0 = 1;
        else if (left0) wrap4 = 1;
        w4p = write4;
    end

    // Reference model: per-entry cycle costs measured from the edge that samples start.
    int e_rise[$];
    logic [15:0] e_sa[$];
    logic [7:0] e_d[$];
    int e_done;
    task automatic model(input bit first);
        int t;
        logic [15:0] sa;
        logic [7:0] d;
        t = first ? PU : 0;
        e_rise.delete(); e_sa.delete(); e_d.delete();
        for (int i = 0; i < 16; i++) begin
            sa = rom[i][23:8];
            d = rom[i][7:0];
            if (sa == 16'hFFFF) begin
                e_done = t + 2;
                return;
            end
            if (sa == 16'hFFFE) t += 2 + DU * int'(d);
            else begin
                e_rise.push_back(t + 3);
                e_sa.push_back(sa);
                e_d.push_back(d);
                t += 3 + lat;
            end
        end
        e_done = t;
    endtask

    task automatic run_table(input bit first, input string name);
        int s, n;
        model(first);
        cap_t.delete(); cap_sa.delete(); cap_d.delete();
        done_t = -1;
        stab_err = 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        s = cyc;
        n_chk++;
        if ({busy, init_done, init_error} !== 3'b100) $display("FAIL %s start: busy/done/err=%b want 100", name, {busy, init_done, init_error});
        else n_pass++;
        for (int i = 0; i < 3000 && !(init_done || init_error); i++) begin
            start = (i == 3 && busy);
            @(negedge clk);
        end
        start = 0;
        @(negedge clk);
        n_chk++;
        if (init_done !== 1'b1) $display("FAIL %s finish: init_done=%b want 1", name, init_done);
        else n_pass++;
        n_chk++;
        if (cap_t.size() != e_rise.size()) $display("FAIL %s writes: got %0d want %0d", name, cap_t.size(), e_rise.size());
        else n_pass++;
        n = cap_t.size() < e_rise.size() ? cap_t.size() : e_rise.size();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (cap_t[i] - s != e_rise[i] || cap_sa[i] !== e_sa[i] || cap_d[i] !== e_d[i])
                $display("FAIL %s write%0d: got t=%0d %h/%h want t=%0d %h/%h", name, i,
                         cap_t[i] - s, cap_sa[i], cap_d[i], e_rise[i], e_sa[i], e_d[i]);
            else n_pass++;
        end
        n_chk++;
        if (done_t - s != e_done) $display("FAIL %s done_time: got %0d want %0d", name, done_t - s, e_done);
        else n_pass++;
        n_chk++;
        if (entry_count !== 5'(e_rise.size()) || busy !== 1'b0 || stab_err != 0)
            $display("FAIL %s status: count=%0d busy=%b unstable=%0d want %0d 0 0", name, entry_count, busy, stab_err, e_rise.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rest_n = 0; start = 0; start4 = 0;
        for (int i = 0; i < 16; i++) rom[i] = 24'hFFFF00;
        for (int i = 0; i < 4; i++) rom4[i] = 24'hFFFF00;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, write, read, init_done, init_error} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {busy, write, read, init_done, init_error});
        else n_pass++;
        n_chk++;
        if (entry_count !== 5'd0 || table_addr !== 4'd0) $display("FAIL reset_counts: count=%0d addr=%0d want 0 0", entry_count, table_addr);
        else n_pass++;
        n_chk++;
        if (sub_addr !== 16'h0 || write_data !== 8'h0) $display("FAIL reset_data: %h/%h want 0000/00", sub_addr, write_data);
        else n_pass++;
        n_chk++;
        if (device_addr !== 8'h78 || resp_ready !== 1'b1) $display("FAIL reset_consts: dev=%h ready=%b want 78 1", device_addr, resp_ready);
        else n_pass++;
        rest_n = 1;
        repeat (4) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || write !== 1'b0) $display("FAIL idle_hold: busy=%b write=%b want 0 0", busy, write);
        else n_pass++;
    endtask

    task automatic test_basic();
        rom[0] = 24'h300E58; rom[1] = 24'h300802; rom[2] = 24'hFFFF00;
        lat = 5;
        run_table(1, "basic");
    endtask

    task automatic test_rerun();
        lat = 2;
        run_table(0, "rerun");
    endtask

    task automatic test_delay();
        rom[0] = 24'hFFFE03; rom[1] = 24'h310311; rom[2] = 24'hFFFF00;
        lat = 5;
        run_table(0, "delay");
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(0, 10);
            for (int i = 0; i < 16; i++) begin
                if (i >= len) rom[i] = 24'hFFFF00;
                else if ($urandom_range(0, 3) == 0) rom[i] = {16'hFFFE, 8'($urandom_range(0, 3))};
                else rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
            end
            lat = $urandom_range(1, 8);
            run_table(0, $sformatf("random%0d", it));
        end
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 16; i++)
            rom[i] = (i % 5 == 2) ? {16'hFFFE, 8'($urandom_range(0, 2))} : {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
        lat = $urandom_range(1, 4);
        run_table(0, "full_table");
    endtask

    task automatic test_timeout();
        int hi = 0, w = 0;
        rom[0] = 24'h308282; rom[1] = 24'hFFFF00;
        resp_left = 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        while (!write && w < 50) begin
            w++;
            @(negedge clk);
        end
        while (write && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        n_chk++;
        if (hi != TO) $display("FAIL timeout_len: write high %0d cycles want %0d", hi, TO);
        else n_pass++;
        n_chk++;
        if ({init_error, init_done, busy, write} !== 4'b1000) $display("FAIL timeout_flags: err/done/busy/write=%b want 1000", {init_error, init_done, busy, write});
        else n_pass++;
        n_chk++;
        if (entry_count !== 5'd0) $display("FAIL timeout_count: got %0d want 0", entry_count);
        else n_pass++;
        resp_left = 1000;
    endtask

    task automatic test_reset_mid_write();
        int w = 0;
        rom[0] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
        rom[1] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
        rom[2] = 24'hFFFE01;
        rom[3] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
        rom[4] = 24'hFFFF00;
        resp_left = 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        n_chk++;
        if (init_error !== 1'b0) $display("FAIL error_clear: init_error=%b want 0", init_error);
        else n_pass++;
        while (!write && w < 50) begin
            w++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (write !== 1'b1) $display("FAIL pre_reset_write: write=%b want 1", write);
        else n_pass++;
        #2 rest_n = 0;
        #1;
        n_chk++;
        if ({write, busy} !== 2'b00 || entry_count !== 5'd0 || table_addr !== 4'd0)
            $display("FAIL async_reset: write=%b busy=%b count=%0d addr=%0d want 0 0 0 0", write, busy, entry_count, table_addr);
        else n_pass++;
        @(negedge clk) rest_n = 1;
        resp_left = 1000;
        repeat (2) @(negedge clk);
        lat = $urandom_range(1, 6);
        run_table(1, "replay");
    endtask

    task automatic test_depth4();
        int w = 0;
        for (int i = 0; i < 4; i++) rom4[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
        @(negedge clk) start4 = 1;
        @(negedge clk) start4 = 0;
        while (!init_done4 && w < 300) begin
            w++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (init_done4 !== 1'b1 || n4 != 4) $display("FAIL depth4_done: done=%b writes=%0d want 1 4", init_done4, n4);
        else n_pass++;
        n_chk++;
        if (entry_count4 !== 3'd4 || table_addr4 !== 2'd3 || wrap4) $display("FAIL depth4_addr: count=%0d addr=%0d wrapped=%b want 4 3 0", entry_count4, table_addr4, wrap4);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rerun();
        test_delay();
        test_random();
        test_full_table();
        test_timeout();
        test_reset_mid_write();
        test_depth4();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
